// File: rtl/idct_pkg.sv
// idct_pkg: shared types, cosine tables and helpers for the 1-D IDCT stream.
// Tables hold C[k][n] = round(c(n)*cos((2k+1)n*pi/2N)*2^11), i.e. Q1.11 (COEF_W=12).
package idct_pkg;

  localparam int unsigned COEF_TAB_W = 12;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } idct_state_t;

  localparam int C4_TAB [4][4] = '{
    '{1024,  1338,  1024,   554},
    '{1024,   554, -1024, -1338},
    '{1024,  -554, -1024,  1338},
    '{1024, -1338,  1024,  -554}
  };

  localparam int C8_TAB [8][8] = '{
    '{724,  1004,  946,   851,  724,   569,  392,   200},
    '{724,   851,  392,  -200, -724, -1004, -946,  -569},
    '{724,   569, -392, -1004, -724,   200,  946,   851},
    '{724,   200, -946,  -569,  724,   851, -392, -1004},
    '{724,  -200, -946,   569,  724,  -851, -392,  1004},
    '{724,  -569, -392,  1004, -724,  -200,  946,  -851},
    '{724,  -851,  392,   200, -724,  1004, -946,   569},
    '{724, -1004,  946,  -851,  724,  -569,  392,  -200}
  };

  // Ceiling log2, minimum 1 so index ports are never zero-width.
  function automatic int unsigned idct_clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Coefficient n of row k for an n_pts-point transform (4 or 8).
  function automatic logic signed [COEF_TAB_W-1:0] idct_row_sel(input int unsigned n_pts,
                                                                 input int unsigned k,
                                                                 input int unsigned n);
    if (n_pts == 8) return COEF_TAB_W'(C8_TAB[3'(k)][3'(n)]);
    else            return COEF_TAB_W'(C4_TAB[2'(k)][2'(n)]);
  endfunction

endpackage

// File: rtl/idct_row_mac.sv
// idct_row_mac: one IDCT row = N signed MACs, round half-up, then clamp or wrap,
// captured in a single output register.
// Ports: clk, reset (async active-low), i_en (load output register),
//        i_x (N packed coefficients), i_coef (N packed cosine constants),
//        o_data (registered spatial sample).
// Build option: IDCT_SAT_EN selects clamping instead of two's complement wrap.
module idct_row_mac
  import idct_pkg::*;
#(
  parameter int unsigned N      = 4,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned COEF_W = 12,
  parameter int unsigned OUT_W  = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_en,
  input  logic [N*DATA_W-1:0]   i_x,
  input  logic [N*COEF_W-1:0]   i_coef,
  output logic [OUT_W-1:0]      o_data
);

  localparam int unsigned PROD_W = DATA_W + COEF_W;
  localparam int unsigned SUM_W  = PROD_W + idct_clog2(N);
  // One spare bit so the rounding constant can never overflow the sum.
  localparam int unsigned RND_W  = SUM_W + 1;
  localparam logic signed [RND_W-1:0] RND_HALF = RND_W'(1) <<< (COEF_W - 2);

  logic signed [SUM_W-1:0] w_sum;
  logic signed [RND_W-1:0] w_rnd;
  logic signed [RND_W-1:0] w_shift;
  logic [OUT_W-1:0]        w_res;

  // Full-width dot product of the coefficient vector with row k.
  always_comb begin : mac
    logic signed [DATA_W-1:0] v_x;
    logic signed [COEF_W-1:0] v_c;
    logic signed [PROD_W-1:0] v_p;
    v_x   = '0;
    v_c   = '0;
    v_p   = '0;
    w_sum = '0;
    for (int unsigned n = 0; n < N; n++) begin
      v_x   = i_x[n*DATA_W +: DATA_W];
      v_c   = i_coef[n*COEF_W +: COEF_W];
      v_p   = PROD_W'(v_x) * PROD_W'(v_c);
      w_sum = w_sum + SUM_W'(v_p);
    end
  end

  assign w_rnd   = RND_W'(w_sum) + RND_HALF;
  assign w_shift = w_rnd >>> (COEF_W - 1);

`ifdef IDCT_SAT_EN
  if (OUT_W >= RND_W) begin : g_wide
    assign w_res = OUT_W'(w_shift);
  end else begin : g_sat
    localparam logic signed [RND_W-1:0] SAT_MAX = {{(RND_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [RND_W-1:0] SAT_MIN = {{(RND_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    always_comb begin
      if (w_shift > SAT_MAX)      w_res = OUT_W'(SAT_MAX);
      else if (w_shift < SAT_MIN) w_res = OUT_W'(SAT_MIN);
      else                        w_res = OUT_W'(w_shift);
    end
  end
`else
  assign w_res = OUT_W'(w_shift);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    o_data <= '0;
    else if (i_en) o_data <= w_res;
  end

endmodule

// File: rtl/idct_1d_stream.sv
// idct_1d_stream: N-point 1-D inverse DCT. Takes one coefficient vector per
// in_valid/in_ready handshake and streams N spatial samples out, one per cycle,
// on out_valid/out_ready with backpressure.
// Ports: clk, reset (async active-low), in_data/in_valid/in_ready (vector in),
//        out_data/out_idx/out_last/out_valid/out_ready (sample stream out).
// Build option: IDCT_SAT_EN clamps results to OUT_W instead of wrapping.
module idct_1d_stream
  import idct_pkg::*;
#(
  parameter int unsigned N      = 4,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned COEF_W = 12,
  parameter int unsigned OUT_W  = 24
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N*DATA_W-1:0]       in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [OUT_W-1:0]          out_data,
  output logic [idct_clog2(N)-1:0]  out_idx,
  output logic                      out_last,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int unsigned K_W = idct_clog2(N);

  idct_state_t           r_state;
  logic [K_W-1:0]        r_k;
  logic [N*DATA_W-1:0]   r_x;
  logic                  r_out_valid;
  logic [K_W-1:0]        r_out_idx;
  logic                  r_out_last;

  logic                  w_adv;
  logic                  w_issue;
  logic                  w_last_k;
  logic                  w_accept;
  logic [N*COEF_W-1:0]   w_coef;

  // The output slot is free when empty or being drained this cycle.
  assign w_adv    = !r_out_valid || out_ready;
  assign w_issue  = (r_state == ST_RUN) && w_adv;
  assign w_last_k = (r_k == K_W'(N - 1));
  // Ready in IDLE, or while issuing the last row so vectors chain without a bubble.
  assign in_ready = reset && ((r_state == ST_IDLE) || (w_issue && w_last_k));
  assign w_accept = in_valid && in_ready;

  // Cosine row for the sample currently being produced.
  always_comb begin
    w_coef = '0;
    for (int unsigned n = 0; n < N; n++) begin
      w_coef[n*COEF_W +: COEF_W] = COEF_W'(idct_row_sel(N, 32'(r_k), n));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_k         <= '0;
      r_x         <= '0;
      r_out_valid <= 1'b0;
      r_out_idx   <= '0;
      r_out_last  <= 1'b0;
    end else begin
      if (w_issue) begin
        r_out_valid <= 1'b1;
        r_out_idx   <= r_k;
        r_out_last  <= w_last_k;
        r_k         <= w_last_k ? '0 : r_k + K_W'(1);
      end else if (w_adv) begin
        r_out_valid <= 1'b0;
      end

      if (w_accept) begin
        r_x     <= in_data;
        r_k     <= '0;
        r_state <= ST_RUN;
      end else if (w_issue && w_last_k) begin
        r_state <= ST_IDLE;
      end
    end
  end

  idct_row_mac #(
    .N      (N),
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .OUT_W  (OUT_W)
  ) u_row_mac (
    .clk    (clk),
    .reset  (reset),
    .i_en   (w_issue),
    .i_x    (r_x),
    .i_coef (w_coef),
    .o_data (out_data)
  );

  assign out_valid = r_out_valid;
  assign out_idx   = r_out_idx;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_idct_1d_stream.sv
// Self-checking bench for idct_1d_stream: N=4/OUT_W=24, N=8/OUT_W=24 and
// N=4/OUT_W=16 instances; row-0 overflow expectation follows IDCT_SAT_EN.
module tb_idct_1d_stream;

`ifdef IDCT_SAT_EN
  localparam int SAT_ROW0 = 32767;
`else
  localparam int SAT_ROW0 = -2498;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic [63:0]        i4_data;
  logic               i4_valid, i4_ready;
  logic signed [23:0] o4_data;
  logic [1:0]         o4_idx;
  logic               o4_last, o4_valid, o4_ready;

  logic [127:0]       i8_data;
  logic               i8_valid, i8_ready;
  logic signed [23:0] o8_data;
  logic [2:0]         o8_idx;
  logic               o8_last, o8_valid, o8_ready;

  logic [63:0]        i16_data;
  logic               i16_valid, i16_ready;
  logic signed [15:0] o16_data;
  logic [1:0]         o16_idx;
  logic               o16_last, o16_valid, o16_ready;

  idct_1d_stream #(.N(4), .DATA_W(16), .COEF_W(12), .OUT_W(24)) u_dut4 (
    .clk(clk), .reset(reset), .in_data(i4_data), .in_valid(i4_valid), .in_ready(i4_ready),
    .out_data(o4_data), .out_idx(o4_idx), .out_last(o4_last), .out_valid(o4_valid),
    .out_ready(o4_ready));

  idct_1d_stream #(.N(8), .DATA_W(16), .COEF_W(12), .OUT_W(24)) u_dut8 (
    .clk(clk), .reset(reset), .in_data(i8_data), .in_valid(i8_valid), .in_ready(i8_ready),
    .out_data(o8_data), .out_idx(o8_idx), .out_last(o8_last), .out_valid(o8_valid),
    .out_ready(o8_ready));

  idct_1d_stream #(.N(4), .DATA_W(16), .COEF_W(12), .OUT_W(16)) u_dut16 (
    .clk(clk), .reset(reset), .in_data(i16_data), .in_valid(i16_valid), .in_ready(i16_ready),
    .out_data(o16_data), .out_idx(o16_idx), .out_last(o16_last), .out_valid(o16_valid),
    .out_ready(o16_ready));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [63:0]      data;
    logic [3:0][31:0] exp;
  } vec_t;
  vec_t vecs [6];

  function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
    logic [63:0] r;
    r = {16'(d), 16'(c), 16'(b), 16'(a)};
    return r;
  endfunction

  function automatic logic [3:0][31:0] mk_exp(input int a, input int b, input int c, input int d);
    logic [3:0][31:0] r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Present a vector to the N=4 unit; returns at the negedge after acceptance.
  task automatic push4(input logic [63:0] d);
    int t;
    t = 0;
    i4_data  = d;
    i4_valid = 1'b1;
    while (!i4_ready && t < 50) begin @(negedge clk); t++; end
    chk("push4_ready", int'(i4_ready), 1);
    @(negedge clk);
    i4_valid = 1'b0;
  endtask

  // Drain four samples from the N=4 unit with out_ready held high.
  task automatic collect4(input logic [3:0][31:0] exp, input string tag);
    for (int i = 0; i < 4; i++) begin
      int t;
      t = 0;
      while (!o4_valid && t < 20) begin @(negedge clk); t++; end
      chk($sformatf("%s_valid%0d", tag, i), int'(o4_valid), 1);
      chk($sformatf("%s_data%0d", tag, i), int'(o4_data), int'(exp[i[1:0]]));
      chk($sformatf("%s_idx%0d", tag, i), int'(o4_idx), i);
      chk($sformatf("%s_last%0d", tag, i), int'(o4_last), (i == 3) ? 1 : 0);
      @(negedge clk);
    end
  endtask

  logic [3:0] bp_pat = 4'b1001;

  initial begin
    int t;
    int ptr;
    int prev_data;
    int prev_idx;
    logic stalled;
    logic [3:0][31:0] e;

    reset = 1'b0;
    i4_data = '0;  i4_valid = 1'b0;  o4_ready = 1'b1;
    i8_data = '0;  i8_valid = 1'b0;  o8_ready = 1'b1;
    i16_data = '0; i16_valid = 1'b0; o16_ready = 1'b1;

    vecs[0].data = pack4(100, 0, 0, 0);     vecs[0].exp = mk_exp(50, 50, 50, 50);
    vecs[1].data = pack4(2048, 0, 0, 0);    vecs[1].exp = mk_exp(1024, 1024, 1024, 1024);
    vecs[2].data = pack4(0, 2048, 0, 0);    vecs[2].exp = mk_exp(1338, 554, -554, -1338);
    vecs[3].data = pack4(0, 0, 0, 1000);    vecs[3].exp = mk_exp(271, -653, 653, -271);
    vecs[4].data = pack4(-100, 0, 0, 0);    vecs[4].exp = mk_exp(-50, -50, -50, -50);
    vecs[5].data = pack4(300, -200, 50, 10); vecs[5].exp = mk_exp(47, 64, 186, 303);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", int'(o4_valid), 0);
    chk("rst_out_data", int'(o4_data), 0);
    chk("rst_out_idx", int'(o4_idx), 0);
    chk("rst_out_last", int'(o4_last), 0);
    chk("rst_in_ready", int'(i4_ready), 0);
    reset = 1'b1;
    #1;
    chk("rel_in_ready", int'(i4_ready), 1);
    @(negedge clk);

    // Table-driven vectors, each with a one-cycle accept-to-y0 latency check
    for (int v = 0; v < 6; v++) begin
      push4(vecs[v].data);
      chk($sformatf("lat_accept_v%0d", v), int'(o4_valid), 0);
      @(negedge clk);
      chk($sformatf("lat_y0_v%0d", v), int'(o4_valid), 1);
      collect4(vecs[v].exp, $sformatf("vec%0d", v));
    end

    // Back-to-back vectors with in_valid held
    i4_data  = pack4(2048, 0, 0, 0);
    i4_valid = 1'b1;
    @(negedge clk);
    i4_data = pack4(0, 0, 0, 0);
    @(negedge clk);
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("b2b_valid%0d", j), int'(o4_valid), 1);
      chk($sformatf("b2b_data%0d", j), int'(o4_data), (j < 4) ? 1024 : 0);
      chk($sformatf("b2b_idx%0d", j), int'(o4_idx), j % 4);
      chk($sformatf("b2b_last%0d", j), int'(o4_last), (j % 4 == 3) ? 1 : 0);
      chk($sformatf("b2b_ready%0d", j), int'(i4_ready), (j == 2 || j == 6 || j == 7) ? 1 : 0);
      if (j == 3) i4_valid = 1'b0;
      @(negedge clk);
    end
    chk("b2b_drained", int'(o4_valid), 0);

    // Backpressure: out_ready follows 1,0,0,1
    push4(pack4(0, 2048, 0, 0));
    e = mk_exp(1338, 554, -554, -1338);
    ptr = 0; t = 0; stalled = 1'b0; prev_data = 0; prev_idx = 0;
    while (ptr < 4 && t < 40) begin
      o4_ready = bp_pat[t[1:0]];
      if (o4_valid) begin
        if (stalled) begin
          chk($sformatf("bp_hold_data%0d", ptr), int'(o4_data), prev_data);
          chk($sformatf("bp_hold_idx%0d", ptr), int'(o4_idx), prev_idx);
        end
        chk($sformatf("bp_data%0d", ptr), int'(o4_data), int'(e[ptr[1:0]]));
        chk($sformatf("bp_idx%0d", ptr), int'(o4_idx), ptr);
        prev_data = int'(o4_data);
        prev_idx  = int'(o4_idx);
        stalled   = !o4_ready;
        if (o4_ready) ptr++;
      end
      @(negedge clk);
      t++;
    end
    o4_ready = 1'b1;
    chk("bp_count", ptr, 4);
    chk("bp_no_extra", int'(o4_valid), 0);

    // Overflow of row 0 at OUT_W=16
    i16_data  = {4{16'h7FFF}};
    i16_valid = 1'b1;
    t = 0;
    while (!i16_ready && t < 20) begin @(negedge clk); t++; end
    chk("sat_accept", int'(i16_ready), 1);
    @(negedge clk);
    i16_valid = 1'b0;
    e = mk_exp(SAT_ROW0, -12544, 12544, 2496);
    for (int i = 0; i < 4; i++) begin
      t = 0;
      while (!o16_valid && t < 20) begin @(negedge clk); t++; end
      chk($sformatf("sat_data%0d", i), int'(o16_data), int'(e[i[1:0]]));
      chk($sformatf("sat_idx%0d", i), int'(o16_idx), i);
      @(negedge clk);
    end

    // N=8 DC-only vector
    i8_data  = 128'(2048);
    i8_valid = 1'b1;
    t = 0;
    while (!i8_ready && t < 20) begin @(negedge clk); t++; end
    chk("n8_accept", int'(i8_ready), 1);
    @(negedge clk);
    i8_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      t = 0;
      while (!o8_valid && t < 20) begin @(negedge clk); t++; end
      chk($sformatf("n8_data%0d", i), int'(o8_data), 724);
      chk($sformatf("n8_idx%0d", i), int'(o8_idx), i);
      chk($sformatf("n8_last%0d", i), int'(o8_last), (i == 7) ? 1 : 0);
      @(negedge clk);
    end

    // Reset asserted mid-vector, after y[1]
    push4(pack4(100, 0, 0, 0));
    t = 0;
    while (!(o4_valid && o4_idx == 2'd1) && t < 20) begin @(negedge clk); t++; end
    chk("mid_seen_y1", int'(o4_idx), 1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_valid", int'(o4_valid), 0);
    chk("mid_rst_data", int'(o4_data), 0);
    chk("mid_rst_ready", int'(i4_ready), 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rel_ready", int'(i4_ready), 1);
    chk("mid_rel_valid", int'(o4_valid), 0);
    push4(pack4(100, 0, 0, 0));
    collect4(mk_exp(50, 50, 50, 50), "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/idct_1d_stream.md
# idct_1d_stream

Parametrised 1-D inverse DCT engine; successor to the fixed 4-input IDCT_test datapath. It accepts one complete N-point coefficient vector per valid/ready handshake and handles input alignment internally, so the host no longer skews inputs. It emits the N spatial samples serially, one per cycle, on a valid/ready output with backpressure. It sits between the coefficient dequantiser and the row/column transpose buffer.

## Interface
- N, 4, IDCT length; legal values 4 or 8
- DATA_W, 16, signed input coefficient width
- COEF_W, 12, signed cosine constant width; format Q1.(COEF_W-1)
- OUT_W, 24, signed output sample width
- clk  in  1  clock; all logic on the rising edge
- reset  in  1  asynchronous, active-low reset
- in_data  in  N*DATA_W  packed vector; element n is in bits [n*DATA_W +: DATA_W]
- in_valid  in  1  in_data is valid
- in_ready  out  1  block accepts a vector this cycle
- out_data  out  OUT_W  spatial sample y[out_idx]
- out_idx  out  clog2(N)  index of the current sample
- out_last  out  1  high with y[N-1]
- out_valid  out  1  out_data is valid
- out_ready  in  1  consumer takes the sample

## Operation
- Computes y[k] = Σ_n C[k][n]·x[n].
  - C[k][n] = round(c(n)·cos((2k+1)nπ/2N)·2^(COEF_W-1)).
  - c(0) = √(1/N); c(n>0) = √(2/N).
- FSM has two states, IDLE and RUN. A cycle "advances" when out_valid is 0 or out_ready is 1.
- IDLE:
  - in_ready = 1.
  - on in_valid, latch in_data into x_reg, set k = 0, go to RUN.
- RUN, each advancing cycle:
  - row k result is loaded into the output register; out_valid = 1, out_idx = k, out_last = (k == N-1).
  - k increments.
  - after issuing k = N-1: go to IDLE, or stay in RUN when a new vector is accepted in the same cycle.
- In RUN, in_ready = 1 only in the advancing cycle that issues k = N-1. This allows back-to-back vectors with no bubble.
- When the cycle does not advance, out_valid stays 1 and out_data, out_idx and out_last stay stable. k and x_reg hold.
- Arithmetic per row:
  - N signed products of DATA_W+COEF_W bits, summed at full width of DATA_W+COEF_W+clog2(N) bits.
  - round half-up: add 2^(COEF_W-2), then arithmetic shift right by COEF_W-1.
  - reduce to OUT_W (see Configuration).
- Reset: state IDLE, k = 0, x_reg = 0, out_valid = 0, out_data = 0, out_idx = 0, out_last = 0, in_ready = 0 while reset is asserted. A vector that is partially emitted when reset asserts is discarded.

## Timing
- Vector accepted at edge t. x_reg is valid after t. y[0] is registered at edge t+1; y[N-1] at edge t+N with no backpressure.
- Sustained throughput is one sample per cycle, i.e. one vector every N cycles.
- in_ready is combinational from state, k and out_ready. It never depends on in_valid.
- No combinational path from in_data to out_data.

## Configuration
- IDCT_SAT_EN defined: the rounded sum clamps to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- IDCT_SAT_EN undefined: the rounded sum wraps, keeping the low OUT_W bits (two's complement truncation).

## Structure
- Package idct_pkg holds:
  - coefficient tables for N = 4 and N = 8 at COEF_W = 12
  - the row-select function
  - a clog2 function
- Sub-module idct_row_mac: N multipliers, adder tree, rounding and saturate/wrap. It is combinational with one output register; the top holds the FSM and handshake.

## Test plan
- N=4, in_data=[100,0,0,0], out_ready=1 -> out_data 50,50,50,50 on four consecutive cycles; out_last on the 4th; y[0] one cycle after accept.
- N=4, in_data=[2048,0,0,0] followed immediately by [0,0,0,0] with in_valid held -> 1024 ×4 then 0 ×4; no idle cycle between vectors; in_ready high only on the issue of k=3.
- Backpressure: out_ready toggled 1,0,0,1 during a vector -> out_data/out_idx held stable while stalled; all four samples delivered in order exactly once.
- Saturation: OUT_W=16, N=4, in_data all 32767, row 0 -> 32767 with IDCT_SAT_EN; -2498 without it.
- Reset mid-vector: assert reset after y[1] -> out_valid drops asynchronously. After release, in_ready=1, and the next vector [100,0,0,0] yields 50 ×4 with out_idx starting at 0.
- N=8, in_data=[2048,0,…,0] -> eight samples of 724 (2048·round(√(1/8)·2048)/2048), out_idx 0..7, out_last on the 8th.
